// File: rtl/flood_pkg.sv
// Shared constants for the Flood-It board: LED-bar state encoding and the
// legal colour-count range used by both the game FSM and the LED driver.
package flood_pkg;

  // LED-bar animation states
  typedef enum logic [1:0] {
    ST_STEADY = 2'd0,
    ST_BLINK  = 2'd1,
    ST_SWEEP  = 2'd2,
    ST_FLASH  = 2'd3
  } bar_state_e;

  // Legal range of selectable colour counts
  localparam int COLOUR_MIN = 3;
  localparam int COLOUR_MAX = 8;

endpackage

// File: rtl/tick_gen.sv
// Animation prescaler: pulses tick for one cycle every TICK_DIV clocks.
// clr restarts the count so the first tick after a clear lands TICK_DIV
// cycles later.
module tick_gen #(
  parameter int TICK_DIV = 25_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int CNT_W = $clog2(TICK_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: clear has priority, otherwise wrap at the last count
  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (clr || (cnt_q == CNT_LAST)) begin
      cnt_d = '0;
    end
  end

  // Prescaler register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = (cnt_q == CNT_LAST);

endmodule

// File: rtl/led_bar_ctrl.sv
// LED-bar driver: thermometer display of the colour count, blink on count
// change, chaser sweep on win and full-bar flash on lose. All outputs are
// registered so the pins see state/value one cycle later.
module led_bar_ctrl
  import flood_pkg::*;
#(
  parameter int NUM_LEDS   = 16,
  parameter int VAL_W      = 4,
  parameter int MIN_VAL    = COLOUR_MIN,
  parameter int MAX_VAL    = COLOUR_MAX,
  parameter int TICK_DIV   = 25_000_000,
  parameter int BLINK_HALF = 6,
  parameter int SWEEP_LAPS = 2,
  parameter int FLASH_HALF = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [VAL_W-1:0]    value,
  input  logic                win,
  input  logic                lose,
  output logic                busy,
  output logic [NUM_LEDS-1:0] led
);

  // Half-period counter is shared by blink and flash
  localparam int H_LIM = (BLINK_HALF > FLASH_HALF) ? BLINK_HALF : FLASH_HALF;
  localparam int H_W   = (H_LIM > 1) ? $clog2(H_LIM) : 1;
  localparam int P_W   = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;
  localparam int LAP_W = (SWEEP_LAPS > 1) ? $clog2(SWEEP_LAPS) : 1;

  localparam logic [H_W-1:0]      BLINK_LAST = H_W'(BLINK_HALF - 1);
  localparam logic [H_W-1:0]      FLASH_LAST = H_W'(FLASH_HALF - 1);
  localparam logic [P_W-1:0]      P_LAST     = P_W'(NUM_LEDS - 1);
  localparam logic [LAP_W-1:0]    LAP_LAST   = LAP_W'(SWEEP_LAPS - 1);
  localparam logic [NUM_LEDS-1:0] LED_ONE    = NUM_LEDS'(1);

  bar_state_e          state_q, state_d;
  logic [H_W-1:0]      h_q, h_d;
  logic [P_W-1:0]      p_q, p_d;
  logic [LAP_W-1:0]    lap_q, lap_d;
  logic [VAL_W-1:0]    value_q;
  logic [NUM_LEDS-1:0] led_q, led_d;
  logic                busy_q, busy_d;
  logic                enter;
  logic                tick;
  logic                change;

  // Thermometer code; out-of-range counts show the full legal range
  function automatic logic [NUM_LEDS-1:0] bar(input logic [VAL_W-1:0] v);
    int n;
    int vi;
    vi = int'(v);
    n  = ((vi >= MIN_VAL) && (vi <= MAX_VAL)) ? vi : MAX_VAL;
    bar = '0;
    for (int i = 0; i < NUM_LEDS; i++) begin
      bar[i] = (i < n);
    end
  endfunction

  tick_gen #(
    .TICK_DIV(TICK_DIV)
  ) u_tick (
    .clk (clk),
    .rst (rst),
    .clr (enter),
    .tick(tick)
  );

  assign change = (value_q != value);

  // Next state and counters; any (re)entry zeroes the counters and prescaler
  always_comb begin
    state_d = state_q;
    h_d     = h_q;
    p_d     = p_q;
    lap_d   = lap_q;
    enter   = 1'b0;
    unique case (state_q)
      ST_STEADY: begin
        if (win) begin
          state_d = ST_SWEEP;
          enter   = 1'b1;
        end else if (lose) begin
          state_d = ST_FLASH;
          enter   = 1'b1;
        end else if (change) begin
          state_d = ST_BLINK;
          enter   = 1'b1;
        end
      end
      ST_BLINK: begin
        if (win) begin
          state_d = ST_SWEEP;
          enter   = 1'b1;
        end else if (lose) begin
          state_d = ST_FLASH;
          enter   = 1'b1;
        end else if (change) begin
          enter = 1'b1;
        end else if (tick) begin
          if (h_q == BLINK_LAST) begin
            state_d = ST_STEADY;
            enter   = 1'b1;
          end else begin
            h_d = h_q + 1'b1;
          end
        end
      end
      ST_SWEEP: begin
        if (win) begin
          enter = 1'b1;
        end else if (tick) begin
          if (p_q == P_LAST) begin
            p_d = '0;
            if (lap_q == LAP_LAST) begin
              state_d = ST_STEADY;
              enter   = 1'b1;
            end else begin
              lap_d = lap_q + 1'b1;
            end
          end else begin
            p_d = p_q + 1'b1;
          end
        end
      end
      ST_FLASH: begin
        if (win) begin
          state_d = ST_SWEEP;
          enter   = 1'b1;
        end else if (lose) begin
          enter = 1'b1;
        end else if (tick) begin
          if (h_q == FLASH_LAST) begin
            state_d = ST_STEADY;
            enter   = 1'b1;
          end else begin
            h_d = h_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_STEADY;
        enter   = 1'b1;
      end
    endcase
    if (enter) begin
      h_d   = '0;
      p_d   = '0;
      lap_d = '0;
    end
  end

  // LED pattern and busy flag for the current state, registered below
  always_comb begin
    led_d  = '0;
    busy_d = (state_q != ST_STEADY);
    unique case (state_q)
      ST_STEADY: led_d = bar(value);
      ST_BLINK:  led_d = h_q[0] ? '0 : bar(value);
      ST_SWEEP:  led_d = LED_ONE << p_q;
      ST_FLASH:  led_d = h_q[0] ? '0 : '1;
      default:   led_d = '0;
    endcase
  end

  // State, counters, value tracking and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_STEADY;
      h_q     <= '0;
      p_q     <= '0;
      lap_q   <= '0;
      value_q <= '0;
      led_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      h_q     <= h_d;
      p_q     <= p_d;
      lap_q   <= lap_d;
      value_q <= value;
      led_q   <= led_d;
      busy_q  <= busy_d;
    end
  end

  assign led  = led_q;
  assign busy = busy_q;

endmodule

// File: tb/tb_led_bar_ctrl.sv
// Directed bench for led_bar_ctrl with a fast prescaler (TICK_DIV=4).
module tb_led_bar_ctrl;

  logic        clk;
  logic        rst;
  logic [3:0]  value;
  logic        win;
  logic        lose;
  logic        busy;
  logic [15:0] led;

  int checks;
  int errors;

  led_bar_ctrl #(
    .NUM_LEDS(16),
    .VAL_W   (4),
    .TICK_DIV(4)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .value(value),
    .win  (win),
    .lose (lose),
    .busy (busy),
    .led  (led)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  val;
    logic [15:0] exp_led;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Advance n rising edges, then settle 1 time unit past the edge
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    logic [15:0] e;
    checks = 0;
    errors = 0;

    vecs[0] = '{4'd9,  16'h00FF};
    vecs[1] = '{4'd0,  16'h00FF};
    vecs[2] = '{4'd3,  16'h0007};
    vecs[3] = '{4'd8,  16'h00FF};
    vecs[4] = '{4'd2,  16'h00FF};
    vecs[5] = '{4'd15, 16'h00FF};
    vecs[6] = '{4'd7,  16'h007F};
    vecs[7] = '{4'd5,  16'h001F};

    // Reset state
    rst = 1'b1; value = 4'd5; win = 1'b0; lose = 1'b0;
    step(3);
    chk("reset_led", 32'(led), 32'h0);
    chk("reset_busy", 32'(busy), 32'h0);
    rst = 1'b0;
    step(1);
    chk("release_led", 32'(led), 32'h001F);
    chk("release_busy", 32'(busy), 32'h0);
    $display("reset release: led=%h busy=%b", led, busy);
    step(30);

    // Table: each change shows the new bar at once, blinks, then settles
    for (int i = 0; i < 8; i++) begin
      value = vecs[i].val;
      step(1);
      chk("vec_led_first", 32'(led), 32'(vecs[i].exp_led));
      chk("vec_busy_first", 32'(busy), 32'h0);
      step(1);
      chk("vec_busy_on", 32'(busy), 32'h1);
      step(24);
      chk("vec_led_steady", 32'(led), 32'(vecs[i].exp_led));
      chk("vec_busy_off", 32'(busy), 32'h0);
      $display("vec %0d: value=%0d led=%h busy=%b", i, vecs[i].val, led, busy);
    end

    // Blink 5 -> 7: bar/blank every 4 clocks for 6 halves
    value = 4'd7;
    for (int k = 0; k <= 25; k++) begin
      step(1);
      if (k == 0 || k == 25) e = 16'h007F;
      else e = (((k - 1) / 4) % 2 == 1) ? 16'h0000 : 16'h007F;
      chk("blink_led", 32'(led), 32'(e));
      chk("blink_busy", 32'(busy), (k >= 1 && k <= 24) ? 32'h1 : 32'h0);
    end
    $display("blink 5->7 done: led=%h busy=%b", led, busy);

    // Win sweep: one-hot walk, two laps, back to the bar
    win = 1'b1;
    step(1);
    win = 1'b0;
    for (int k = 1; k <= 129; k++) begin
      step(1);
      e = (k == 129) ? 16'h007F : (16'h0001 << (((k - 1) / 4) % 16));
      chk("sweep_led", 32'(led), 32'(e));
      chk("sweep_busy", 32'(busy), (k <= 128) ? 32'h1 : 32'h0);
    end
    $display("win sweep done: led=%h busy=%b", led, busy);

    // Lose flash: full bar on/off for 8 halves
    lose = 1'b1;
    step(1);
    lose = 1'b0;
    for (int k = 1; k <= 33; k++) begin
      step(1);
      if (k == 33) e = 16'h007F;
      else e = (((k - 1) / 4) % 2 == 1) ? 16'h0000 : 16'hFFFF;
      chk("flash_led", 32'(led), 32'(e));
      chk("flash_busy", 32'(busy), (k <= 32) ? 32'h1 : 32'h0);
    end
    $display("lose flash done: led=%h busy=%b", led, busy);

    // Lose, then win 3 cycles later: sweep restarts from bit 0, lap 0
    lose = 1'b1;
    step(1);
    lose = 1'b0;
    step(2);
    win = 1'b1;
    chk("preempt_flash_led", 32'(led), 32'hFFFF);
    step(1);
    win = 1'b0;
    chk("preempt_k3_led", 32'(led), 32'hFFFF);
    step(1);
    chk("preempt_bit0_led", 32'(led), 32'h0001);
    step(3);
    chk("preempt_bit0_hold", 32'(led), 32'h0001);
    step(1);
    chk("preempt_bit1_led", 32'(led), 32'h0002);
    chk("preempt_busy", 32'(busy), 32'h1);
    step(122);
    chk("preempt_last_led", 32'(led), 32'h8000);
    step(2);
    chk("preempt_end_led", 32'(led), 32'h007F);
    chk("preempt_end_busy", 32'(busy), 32'h0);
    $display("lose->win preempt done: led=%h busy=%b", led, busy);

    // Asynchronous reset in the middle of a sweep
    win = 1'b1;
    step(1);
    win = 1'b0;
    step(10);
    chk("midsweep_busy", 32'(busy), 32'h1);
    rst = 1'b1;
    #1;
    chk("async_rst_led", 32'(led), 32'h0);
    chk("async_rst_busy", 32'(busy), 32'h0);
    $display("mid-sweep reset: led=%h busy=%b", led, busy);
    step(2);
    rst = 1'b0;
    step(1);
    chk("post_rst_led", 32'(led), 32'h007F);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
